// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, the dark pattern,
// the active-low hex glyph table and a decode helper used by the digit decoder.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam seg_t SEG_OFF = 8'hFF;

  localparam seg_t SEG_GLYPH_BITS = 8'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                       (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                       (1 << SEG_G));

  localparam logic [15:0][7:0] HEX_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic seg_t hex_decode(input logic [3:0] value, input logic dot);
    seg_t seg;
    seg = HEX_TABLE[value] | ~SEG_GLYPH_BITS;
    seg[SEG_DP] = ~dot;
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-seven-segment decoder with decimal point, active-low outputs.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dot,
  output logic [7:0] seg
);

  // Glyph lookup plus decimal point, both driven low when lit.
  always_comb begin
    seg = hex_decode(value, dot);
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit seven-segment scanner: per-frame input snapshot,
// PWM brightness, leading-zero blanking, blinking and a dead cycle per slot.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BRIGHT_BITS  = 4,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [4*NUM_DIGITS-1:0]   DIGITS,
  input  logic [NUM_DIGITS-1:0]     DOTS,
  input  logic [NUM_DIGITS-1:0]     DIGIT_EN,
  input  logic [NUM_DIGITS-1:0]     BLINK_MASK,
  input  logic                      BLANK_LZ,
  input  logic [BRIGHT_BITS-1:0]    BRIGHTNESS,
  output logic [7:0]                SEG7LIGHT,
  output logic [NUM_DIGITS-1:0]     SEG_SELECT,
  output logic                      FRAME_DONE
);

  localparam int SLOT_TICKS = CLK_HZ / REFRESH_HZ;
  localparam int SUB_TICKS  = SLOT_TICKS >> BRIGHT_BITS;
  localparam int PRESC_W    = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam int SUB_W      = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRESC_W-1:0]      prescaler_q, prescaler_d;
  logic [SUB_W-1:0]        sub_cnt_q, sub_cnt_d;
  logic [BRIGHT_BITS-1:0]  sub_idx_q, sub_idx_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                    blink_on_q, blink_on_d;

  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dots_q, snap_dots_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
  logic                    snap_lz_q, snap_lz_d;
  logic [BRIGHT_BITS-1:0]  snap_bright_q, snap_bright_d;

  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_tick;
  logic                    frame_tick;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   visible;
  logic [3:0]              cur_digit;
  logic                    cur_dot;
  logic                    cur_visible;
  logic [7:0]              cur_seg;
  logic                    pwm_on;
  logic                    active;

  // Slot timing, scan index, blink phase and the frame-boundary snapshot.
  always_comb begin
    slot_tick     = (prescaler_q == PRESC_W'(SLOT_TICKS - 1));
    frame_tick    = slot_tick && (index_q == IDX_W'(NUM_DIGITS - 1));
    prescaler_d   = slot_tick ? '0 : prescaler_q + 1'b1;
    sub_cnt_d     = sub_cnt_q;
    sub_idx_d     = sub_idx_q;
    index_d       = index_q;
    frame_cnt_d   = frame_cnt_q;
    blink_on_d    = blink_on_q;
    snap_digits_d = snap_digits_q;
    snap_dots_d   = snap_dots_q;
    snap_en_d     = snap_en_q;
    snap_blink_d  = snap_blink_q;
    snap_lz_d     = snap_lz_q;
    snap_bright_d = snap_bright_q;
    if (slot_tick) begin
      sub_cnt_d = '0;
      sub_idx_d = '0;
      index_d   = frame_tick ? '0 : index_q + 1'b1;
    end else if (sub_cnt_q == SUB_W'(SUB_TICKS - 1)) begin
      sub_cnt_d = '0;
      sub_idx_d = sub_idx_q + 1'b1;
    end else begin
      sub_cnt_d = sub_cnt_q + 1'b1;
    end
    if (frame_tick) begin
      if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      snap_digits_d = DIGITS;
      snap_dots_d   = DOTS;
      snap_en_d     = DIGIT_EN;
      snap_blink_d  = BLINK_MASK;
      snap_lz_d     = BLANK_LZ;
      snap_bright_d = BRIGHTNESS;
    end
  end

  // Per-digit visibility: enable, leading-zero run from the top digit down, blink phase.
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (snap_digits_q[4*i +: 4] == 4'h0);
      if (i > 0) begin
        lz_blank[i] = snap_lz_q && upper_zero;
      end
    end
    visible = snap_en_q & ~lz_blank & ~(snap_blink_q & {NUM_DIGITS{~blink_on_q}});
  end

  // Pick the snapshot value, dot and visibility of the digit being scanned.
  always_comb begin
    cur_digit   = 4'h0;
    cur_dot     = 1'b0;
    cur_visible = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == IDX_W'(i)) begin
        cur_digit   = snap_digits_q[4*i +: 4];
        cur_dot     = snap_dots_q[i];
        cur_visible = visible[i];
      end
    end
  end

  seg7_hex_decoder u_decoder (
    .value (cur_digit),
    .dot   (cur_dot),
    .seg   (cur_seg)
  );

  // Next pin values: lit only when visible, past the dead cycle and inside the PWM window.
  always_comb begin
    pwm_on       = (prescaler_q != '0) && (sub_idx_q <= snap_bright_q);
    active       = cur_visible && pwm_on;
    seg_d        = active ? cur_seg : SEG_OFF;
    sel_d        = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_d[i] = !(active && (index_q == IDX_W'(i)));
    end
    frame_done_d = frame_tick;
  end

  // State and output registers; reset forces a dark display with an empty snapshot.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      prescaler_q   <= '0;
      sub_cnt_q     <= '0;
      sub_idx_q     <= '0;
      index_q       <= '0;
      frame_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      snap_digits_q <= '0;
      snap_dots_q   <= '0;
      snap_en_q     <= '0;
      snap_blink_q  <= '0;
      snap_lz_q     <= 1'b0;
      snap_bright_q <= '0;
      seg_q         <= SEG_OFF;
      sel_q         <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      sub_cnt_q     <= sub_cnt_d;
      sub_idx_q     <= sub_idx_d;
      index_q       <= index_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_on_q    <= blink_on_d;
      snap_digits_q <= snap_digits_d;
      snap_dots_q   <= snap_dots_d;
      snap_en_q     <= snap_en_d;
      snap_blink_q  <= snap_blink_d;
      snap_lz_q     <= snap_lz_d;
      snap_bright_q <= snap_bright_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign SEG7LIGHT  = seg_q;
  assign SEG_SELECT = sel_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: directed display scenarios plus
// randomized inputs, compared against a cycle-arithmetic reference model.
module tb_seven_segment_scanner;

  localparam int NUM   = 4;
  localparam int SLOT  = 16;
  localparam int SUB   = 1;
  localparam int FRAME = SLOT * NUM;
  localparam int BF    = 2;
  localparam int MAXF  = 1024;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] DIGITS;
  logic [3:0]  DOTS;
  logic [3:0]  DIGIT_EN;
  logic [3:0]  BLINK_MASK;
  logic        BLANK_LZ;
  logic [3:0]  BRIGHTNESS;
  logic [7:0]  SEG7LIGHT;
  logic [3:0]  SEG_SELECT;
  logic        FRAME_DONE;

  int assert_count = 0;
  int fail_count   = 0;

  int unsigned cyc = 0;
  logic [15:0] hist_digits [MAXF];
  logic [3:0]  hist_dots   [MAXF];
  logic [3:0]  hist_en     [MAXF];
  logic [3:0]  hist_blink  [MAXF];
  logic        hist_lz     [MAXF];
  logic [3:0]  hist_bright [MAXF];

  logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int         prof_count [4];
  int         prof_first [4];
  logic [7:0] prof_seg   [4];
  int         prof_frame;

  seven_segment_scanner #(
    .NUM_DIGITS   (NUM),
    .CLK_HZ       (1600),
    .REFRESH_HZ   (100),
    .BRIGHT_BITS  (4),
    .BLINK_FRAMES (BF)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DIGITS     (DIGITS),
    .DOTS       (DOTS),
    .DIGIT_EN   (DIGIT_EN),
    .BLINK_MASK (BLINK_MASK),
    .BLANK_LZ   (BLANK_LZ),
    .BRIGHTNESS (BRIGHTNESS),
    .SEG7LIGHT  (SEG7LIGHT),
    .SEG_SELECT (SEG_SELECT),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Counts clock edges since reset release and records the inputs seen at each frame boundary.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cyc <= 0;
    end else begin
      if ((cyc % FRAME == FRAME - 1) && ((cyc + 1) / FRAME < MAXF)) begin
        hist_digits[(cyc + 1) / FRAME] <= DIGITS;
        hist_dots[(cyc + 1) / FRAME]   <= DOTS;
        hist_en[(cyc + 1) / FRAME]     <= DIGIT_EN;
        hist_blink[(cyc + 1) / FRAME]  <= BLINK_MASK;
        hist_lz[(cyc + 1) / FRAME]     <= BLANK_LZ;
        hist_bright[(cyc + 1) / FRAME] <= BRIGHTNESS;
      end
      cyc <= cyc + 1;
    end
  end

  // Expected pins after n edges: they show the slot position of edge n-1.
  function automatic void model(input int unsigned n, output logic [7:0] eseg,
                                output logic [3:0] esel, output logic efd);
    int unsigned c, p, idx, f;
    logic [15:0] dg;
    logic [3:0]  dt, en, bm, br, value;
    logic        lz, vis;
    eseg = 8'hFF;
    esel = 4'hF;
    efd  = (n > 0) && (n % FRAME == 0);
    if (n == 0) return;
    c   = n - 1;
    p   = c % SLOT;
    idx = (c / SLOT) % NUM;
    f   = c / FRAME;
    if (f == 0 || f >= MAXF) begin
      dg = '0; dt = '0; en = '0; bm = '0; lz = 1'b0; br = '0;
    end else begin
      dg = hist_digits[f]; dt = hist_dots[f]; en = hist_en[f];
      bm = hist_blink[f]; lz = hist_lz[f]; br = hist_bright[f];
    end
    value = 4'(dg >> (4 * idx));
    vis = en[idx] && !(bm[idx] && ((f / BF) % 2 == 1)) &&
          !(lz && idx > 0 && ((dg >> (4 * idx)) == 16'h0));
    if (vis && p != 0 && (p / SUB) <= br) begin
      eseg = {~dt[idx], ~seg_on[value]};
      esel = ~(4'b0001 << idx);
    end
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] es;
    logic [3:0] ss;
    logic       fd;
    model(cyc, es, ss, fd);
    assert_count++;
    assert (SEG7LIGHT === es) else begin
      fail_count++;
      $error("FAIL %s seg7light observed %h expected %h at cycle %0d", tag, SEG7LIGHT, es, cyc);
    end
    assert_count++;
    assert (SEG_SELECT === ss) else begin
      fail_count++;
      $error("FAIL %s seg_select observed %b expected %b at cycle %0d", tag, SEG_SELECT, ss, cyc);
    end
    assert_count++;
    assert (FRAME_DONE === fd) else begin
      fail_count++;
      $error("FAIL %s frame_done observed %b expected %b at cycle %0d", tag, FRAME_DONE, fd, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] dg, input logic [3:0] dt, input logic [3:0] en,
                               input logic [3:0] bm, input logic lz, input logic [3:0] br);
    DIGITS     = dg;
    DOTS       = dt;
    DIGIT_EN   = en;
    BLINK_MASK = bm;
    BLANK_LZ   = lz;
    BRIGHTNESS = br;
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      checkOutput(tag);
    end
  endtask

  task automatic waitFrameDone(input string tag, output int cycles);
    bit found = 1'b0;
    cycles = 0;
    while (!found && cycles < 200) begin
      @(negedge CLK);
      cycles++;
      checkOutput(tag);
      if (FRAME_DONE === 1'b1) found = 1'b1;
    end
    assert_count++;
    assert (found) else begin
      fail_count++;
      $error("FAIL %s frame_done observed none expected a pulse within 200 cycles", tag);
    end
  endtask

  task automatic profileFrame(input string tag, input int change_at, input logic [15:0] new_digits);
    logic [3:0] pat;
    checkValue({tag, "_align"}, cyc % FRAME, 0);
    prof_frame = int'(cyc / FRAME);
    for (int d = 0; d < NUM; d++) begin
      prof_count[d] = 0;
      prof_first[d] = -1;
      prof_seg[d]   = 8'hFF;
    end
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge CLK);
      checkOutput(tag);
      for (int d = 0; d < NUM; d++) begin
        pat = ~(4'b0001 << d);
        if (SEG_SELECT === pat) begin
          prof_count[d]++;
          prof_seg[d] = SEG7LIGHT;
          if (prof_first[d] < 0) prof_first[d] = k;
        end
      end
      if (k == change_at) DIGITS = new_digits;
    end
  endtask

  initial begin
    logic [7:0]  exp_seg [4];
    logic [15:0] nd;
    int          period;
    int          exp2;

    RESET = 1'b0;
    applyStimulus(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    repeat (3) @(negedge CLK);
    checkValue("reset_seg", SEG7LIGHT, 8'hFF);
    checkValue("reset_sel", SEG_SELECT, 4'hF);
    checkValue("reset_fd", FRAME_DONE, 1'b0);
    RESET = 1'b1;

    $display("[TB] first frame after reset and basic scan");
    applyStimulus(16'h12AF, 4'b0000, 4'b1111, 4'b0000, 1'b0, 4'hF);
    profileFrame("first_dark", 0, 16'h0);
    for (int d = 0; d < NUM; d++) checkValue("first_dark_cnt", prof_count[d], 0);
    profileFrame("scan_12af", 0, 16'h0);
    exp_seg = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    for (int d = 0; d < NUM; d++) begin
      checkValue("scan_cnt", prof_count[d], 15);
      checkValue("scan_first", prof_first[d], 16 * d + 2);
      checkValue("scan_seg", prof_seg[d], exp_seg[d]);
    end

    $display("[TB] leading-zero blanking");
    applyStimulus(16'h0005, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'hF);
    waitFrameDone("lz_sync", period);
    profileFrame("lz_0005", 0, 16'h0);
    checkValue("lz5_cnt0", prof_count[0], 15);
    for (int d = 1; d < NUM; d++) checkValue("lz5_cnt_hi", prof_count[d], 0);
    checkValue("lz5_seg0", prof_seg[0], 8'h92);
    applyStimulus(16'h0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'hF);
    waitFrameDone("lz0_sync", period);
    profileFrame("lz_0000", 0, 16'h0);
    checkValue("lz0_cnt0", prof_count[0], 15);
    for (int d = 1; d < NUM; d++) checkValue("lz0_cnt_hi", prof_count[d], 0);
    checkValue("lz0_seg0", prof_seg[0], 8'hC0);

    $display("[TB] brightness and decimal point");
    applyStimulus(16'h12AF, 4'b0010, 4'b1111, 4'b0000, 1'b0, 4'h3);
    waitFrameDone("pwm_sync", period);
    profileFrame("pwm_3", 0, 16'h0);
    for (int d = 0; d < NUM; d++) begin
      checkValue("pwm_cnt", prof_count[d], 3);
      checkValue("pwm_first", prof_first[d], 16 * d + 2);
    end
    checkValue("pwm_dp_seg1", prof_seg[1], 8'h08);
    checkValue("pwm_seg0", prof_seg[0], 8'h8E);

    $display("[TB] mid-frame input change");
    applyStimulus(16'h12AF, 4'b0000, 4'b1111, 4'b0000, 1'b0, 4'hF);
    waitFrameDone("mid_sync", period);
    nd = 16'($urandom) ^ 16'h5A5A;
    profileFrame("midframe", 20, nd);
    checkValue("mid_seg0", prof_seg[0], 8'h8E);
    checkValue("mid_seg1", prof_seg[1], 8'h88);
    checkValue("mid_seg2", prof_seg[2], 8'hA4);
    checkValue("mid_seg3", prof_seg[3], 8'hF9);
    profileFrame("newframe", 0, 16'h0);
    checkValue("new_seg0", prof_seg[0], {1'b1, ~seg_on[nd[3:0]]});
    checkValue("new_seg3", prof_seg[3], {1'b1, ~seg_on[nd[15:12]]});
    waitFrameDone("period", period);
    checkValue("frame_period", period, FRAME);

    $display("[TB] reset in the middle of a slot");
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    checkValue("midrst_seg", SEG7LIGHT, 8'hFF);
    checkValue("midrst_sel", SEG_SELECT, 4'hF);
    checkValue("midrst_fd", FRAME_DONE, 1'b0);
    @(negedge CLK);
    checkOutput("in_reset");
    RESET = 1'b1;
    profileFrame("post_reset_dark", 0, 16'h0);
    for (int d = 0; d < NUM; d++) checkValue("post_reset_cnt", prof_count[d], 0);

    $display("[TB] blinking digit 2");
    applyStimulus(16'h12AF, 4'b0000, 4'b1111, 4'b0100, 1'b0, 4'hF);
    waitFrameDone("blink_sync", period);
    for (int fr = 0; fr < 8; fr++) begin
      profileFrame("blink", 0, 16'h0);
      exp2 = (((prof_frame / BF) % 2) == 0) ? 15 : 0;
      checkValue("blink_cnt2", prof_count[2], exp2);
      checkValue("blink_cnt0", prof_count[0], 15);
      checkValue("blink_cnt3", prof_count[3], 15);
    end

    $display("[TB] randomized inputs");
    for (int r = 0; r < 40; r++) begin
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), 4'($urandom));
      runCycles(int'($urandom_range(1, 100)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
